// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_store_unit_pkg                                              |
// | Brief   : RV32I load/store width codes, LSU state encoding, legality check |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package load_store_unit_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_RESP = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        ST_ACC1 = 2'd3
`endif
    } lsu_state_e;

    // Width-code legality only; alignment is judged separately by the caller.
    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            c_F3_B, c_F3_H, c_F3_W: ok = 1'b1;
            c_F3_BU, c_F3_HU:       ok = !we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_align                                                        |
// | Brief   : Byte-enable generation, store lane shift, load extract/extend    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_lo,
    input  logic [31:0] i_rdata_hi,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_wdata_lo,
    output logic [31:0] o_wdata_hi,
    output logic [31:0] o_rdata_ext
);

    logic [3:0]  w_mask;
    logic [7:0]  w_be8;
    logic [4:0]  w_shamt;
    logic [63:0] w_wd64;
    logic [31:0] w_rd32;

    always_comb begin
        w_mask = 4'b1111;
        case (i_funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    // Upper halves describe the lanes that spill into the following word.
    assign w_shamt = {i_byte_off, 3'b000};
    assign w_be8   = {4'b0000, w_mask} << i_byte_off;
    assign w_wd64  = {32'd0, i_wdata} << w_shamt;
    assign w_rd32  = 32'({i_rdata_hi, i_rdata_lo} >> w_shamt);

    assign o_be_lo    = w_be8[3:0];
    assign o_be_hi    = w_be8[7:4];
    assign o_wdata_lo = w_wd64[31:0];
    assign o_wdata_hi = w_wd64[63:32];

    always_comb begin
        o_rdata_ext = w_rd32;
        case (i_funct3)
            c_F3_B:  o_rdata_ext = {{24{w_rd32[7]}}, w_rd32[7:0]};
            c_F3_H:  o_rdata_ext = {{16{w_rd32[15]}}, w_rd32[15:0]};
            c_F3_BU: o_rdata_ext = {24'd0, w_rd32[7:0]};
            c_F3_HU: o_rdata_ext = {16'd0, w_rd32[15:0]};
            default: o_rdata_ext = w_rd32;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_store_unit                                                  |
// | Brief   : RV32I MEM-stage load/store engine, byte-enabled variable-latency |
// |           memory port. LSU_MISALIGN_SPLIT_EN: split word-crossing H/W.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_AW = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    lsu_state_e        r_state, w_state_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [3:0]        r_mem_be, w_mem_be_nxt;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;
    logic [2:0]        r_f3, w_f3_nxt;
    logic [1:0]        r_k, w_k_nxt;

    logic              w_req_legal;
    logic              w_done;
    logic [2:0]        w_al_f3;
    logic [1:0]        w_al_k;
    logic [31:0]       w_al_rd_lo, w_al_rd_hi;
    logic [3:0]        w_be_lo, w_be_hi;
    logic [31:0]       w_wd_lo, w_wd_hi, w_rd_ext;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              r_split, w_split_nxt;
    logic [3:0]        r_be_hi, w_be_hi_nxt;
    logic [31:0]       r_wd_hi, w_wd_hi_nxt;
    logic [31:0]       r_rd_lo, w_rd_lo_nxt;

    assign w_req_legal = lsu_f3_legal(req_we, req_funct3);
    assign w_al_rd_lo  = (r_state == ST_ACC1) ? r_rd_lo : mem_rdata;
    assign w_al_rd_hi  = (r_state == ST_ACC1) ? mem_rdata : 32'd0;
`else
    logic              w_misaligned;
    logic              w_unused;

    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3 == c_F3_W) && (req_addr[1:0] != 2'b00));
    assign w_req_legal  = lsu_f3_legal(req_we, req_funct3) && !w_misaligned;
    assign w_al_rd_lo   = mem_rdata;
    assign w_al_rd_hi   = 32'd0;
    assign w_unused     = &{1'b0, w_be_hi, w_wd_hi};
`endif

    // The single aligner serves the incoming request in IDLE and the latched one afterwards.
    assign w_al_f3 = (r_state == ST_IDLE) ? req_funct3    : r_f3;
    assign w_al_k  = (r_state == ST_IDLE) ? req_addr[1:0] : r_k;

    lsu_align u_align (
        .i_funct3    (w_al_f3),
        .i_byte_off  (w_al_k),
        .i_wdata     (req_wdata),
        .i_rdata_lo  (w_al_rd_lo),
        .i_rdata_hi  (w_al_rd_hi),
        .o_be_lo     (w_be_lo),
        .o_be_hi     (w_be_hi),
        .o_wdata_lo  (w_wd_lo),
        .o_wdata_hi  (w_wd_hi),
        .o_rdata_ext (w_rd_ext)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_be_nxt    = r_mem_be;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = 32'd0;
        w_f3_nxt        = r_f3;
        w_k_nxt         = r_k;
        w_done          = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        w_split_nxt     = r_split;
        w_be_hi_nxt     = r_be_hi;
        w_wd_hi_nxt     = r_wd_hi;
        w_rd_lo_nxt     = r_rd_lo;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_req_legal) begin
                        w_state_nxt     = ST_ACC0;
                        w_mem_en_nxt    = 1'b1;
                        w_mem_we_nxt    = req_we;
                        w_mem_be_nxt    = w_be_lo;
                        w_mem_addr_nxt  = req_addr[MEM_AW+1:2];
                        w_mem_wdata_nxt = req_we ? w_wd_lo : 32'd0;
                        w_f3_nxt        = req_funct3;
                        w_k_nxt         = req_addr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                        w_split_nxt     = |w_be_hi;
                        w_be_hi_nxt     = w_be_hi;
                        w_wd_hi_nxt     = w_wd_hi;
`endif
                    end else begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end
                end
            end
            ST_ACC0: begin
                if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (r_split) begin
                        w_state_nxt     = ST_ACC1;
                        w_mem_be_nxt    = r_be_hi;
                        w_mem_addr_nxt  = r_mem_addr + MEM_AW'(1);
                        w_mem_wdata_nxt = r_mem_we ? r_wd_hi : 32'd0;
                        w_rd_lo_nxt     = mem_rdata;
                    end else
`endif
                    begin
                        w_done = 1'b1;
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC1: begin
                if (mem_ack) begin
                    w_done = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Last ack of the transaction: release the memory port and return the result.
        if (w_done) begin
            w_state_nxt     = ST_RESP;
            w_mem_en_nxt    = 1'b0;
            w_mem_we_nxt    = 1'b0;
            w_mem_be_nxt    = 4'b0000;
            w_mem_addr_nxt  = '0;
            w_mem_wdata_nxt = 32'd0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = r_mem_we ? 32'd0 : w_rd_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_f3        <= 3'd0;
            r_k         <= 2'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split     <= 1'b0;
            r_be_hi     <= 4'b0000;
            r_wd_hi     <= 32'd0;
            r_rd_lo     <= 32'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_f3        <= w_f3_nxt;
            r_k         <= w_k_nxt;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split     <= w_split_nxt;
            r_be_hi     <= w_be_hi_nxt;
            r_wd_hi     <= w_wd_hi_nxt;
            r_rd_lo     <= w_rd_lo_nxt;
`endif
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_load_store_unit                                               |
// | Brief   : Randomized bench for load_store_unit against a byte-level model  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

    localparam int MEM_AW = 30;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;
    logic              mem_ack = 1'b0;

    load_store_unit #(.MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    int        n_total = 0;
    int        n_pass  = 0;
    int        wait_cfg = 0;
    int        ack_cnt = 0;
    bit [31:0] tb_mem  [0:63];
    bit [7:0]  ref_mem [0:255];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory responder: acks after wait_cfg idle cycles per access.
    always @(negedge clk) begin
        if (mem_ack || !mem_en) ack_cnt = 0;
        if (mem_en && ack_cnt >= wait_cfg) begin
            mem_ack   = 1'b1;
            mem_rdata = tb_mem[mem_addr[5:0]];
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_en) ack_cnt++;
        end
    end

    always @(posedge clk) begin
        if (mem_en && mem_ack && mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) tb_mem[mem_addr[5:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    function automatic int f_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit f_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
        if (we && f3[2]) return 1'b0;
`ifndef LSU_MISALIGN_SPLIT_EN
        if ((a % f_size(f3)) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Which lanes of access j (0 = first word, 1 = next word) the request touches.
    task automatic f_lanes(input logic [31:0] a, input int sz, input logic [31:0] wd, input int j,
                           output logic [3:0] be, output logic [31:0] lane_mask, output logic [31:0] exp_wd);
        int p;
        be = 4'b0000; lane_mask = 32'd0; exp_wd = 32'd0;
        for (int i = 0; i < sz; i++) begin
            p = int'(a[1:0]) + i;
            if (p / 4 == j) begin
                be[p % 4] = 1'b1;
                lane_mask[8*(p%4) +: 8] = 8'hFF;
                exp_wd[8*(p%4) +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, output logic [31:0] got);
        bit          legal, seen, prev_wait;
        int          sz, nacc, nseen, en_cyc, idx;
        logic [31:0] exp_rd, lm, ewd, sv_addr, sv_wd;
        logic [4:0]  sv_webe;
        logic [3:0]  ebe;
        legal = f_legal(we, f3, a);
        sz    = f_size(f3);
        nacc  = !legal ? 0 : ((int'(a[1:0]) + sz > 4) ? 2 : 1);
        exp_rd = 32'd0;
        if (legal && !we) begin
            for (int i = 0; i < sz; i++) begin
                idx = int'((a + 32'(i)) & 32'hFF);
                exp_rd[8*i +: 8] = ref_mem[idx];
            end
            if (f3 == 3'b000) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
            if (f3 == 3'b001) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
        end
        got = 32'd0; seen = 0; prev_wait = 0; nseen = 0; en_cyc = 0;
        sv_addr = 0; sv_wd = 0; sv_webe = 0;

        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        wait_cfg = waits; req_valid = 1'b1;
        #1 chk("req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                seen = 1;
                got  = rsp_rdata;
                chk("latency", c, legal ? nacc * (waits + 1) + 1 : 1);
                chk("rsp_err", rsp_err, !legal);
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("en_cycles", en_cyc, legal ? nacc * (waits + 1) : 0);
                chk("acc_count", nseen, nacc);
            end else if (mem_en) begin
                en_cyc++;
                if (prev_wait) begin
                    chk("stable_webe", {27'd0, mem_we, mem_be}, {27'd0, sv_webe});
                    chk("stable_addr", 32'(mem_addr), sv_addr);
                    chk("stable_wdata", mem_wdata, sv_wd);
                end
                if (mem_ack) begin
                    f_lanes(a, sz, wd, nseen, ebe, lm, ewd);
                    chk("mem_be", mem_be, ebe);
                    chk("mem_addr", 32'(mem_addr), 32'(MEM_AW'((a >> 2) + 32'(nseen))));
                    chk("mem_we", mem_we, we);
                    if (we) chk("mem_wdata", mem_wdata & lm, ewd);
                    nseen++;
                    prev_wait = 0;
                end else begin
                    prev_wait = 1;
                    sv_webe = {mem_we, mem_be};
                    sv_addr = 32'(mem_addr);
                    sv_wd   = mem_wdata;
                end
            end
        end
        chk("rsp_seen", seen, 1'b1);
        @(negedge clk);
        #1;
        chk("rsp_pulse", rsp_valid, 1'b0);
        if (legal && we)
            for (int i = 0; i < sz; i++) begin
                idx = int'((a + 32'(i)) & 32'hFF);
                ref_mem[idx] = wd[8*i +: 8];
            end
    endtask

    initial begin
        logic [31:0] r;
        bit          any_rsp;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp", {rsp_valid, rsp_err, mem_en, mem_we}, 4'b0000);
        chk("rst_be", mem_be, 4'b0000);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, r);
        do_txn(1'b1, 3'b010, 32'h0C0, 32'h80F01234, 1, r);
        do_txn(1'b0, 3'b000, 32'h0C2, 32'h0, 0, r);
        chk("lb_sign", r, 32'hFFFFFFF0);
        do_txn(1'b0, 3'b100, 32'h0C2, 32'h0, 2, r);
        chk("lbu_zero", r, 32'h000000F0);
        do_txn(1'b0, 3'b001, 32'h0C2, 32'h0, 0, r);
        chk("lh_sign", r, 32'hFFFF80F0);
        do_txn(1'b1, 3'b000, 32'h203, 32'h0000005A, 3, r);
        do_txn(1'b0, 3'b011, 32'h000, 32'h0, 0, r);
        do_txn(1'b1, 3'b100, 32'h010, 32'h12345678, 0, r);
        do_txn(1'b1, 3'b010, 32'h100, 32'hAABBCCDD, 0, r);
        do_txn(1'b1, 3'b010, 32'h104, 32'h11223344, 0, r);
        do_txn(1'b0, 3'b010, 32'h102, 32'h0, 0, r);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("lw_split", r, 32'h3344AABB);
        do_txn(1'b1, 3'b001, 32'h0FB, 32'h0000BEEF, 1, r);
        do_txn(1'b0, 3'b101, 32'h0FB, 32'h0, 0, r);
        chk("lhu_wrap", r, 32'h0000BEEF);
`endif

        // Drop an access in flight with reset.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h010; wait_cfg = 6; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1 chk("rst_mid_en_pre", mem_en, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_en", mem_en, 1'b0);
        any_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            #1 any_rsp |= rsp_valid;
        end
        chk("rst_mid_norsp", any_rsp, 1'b0);
        rst_n = 1'b1;
        #1 chk("rst_mid_ready", req_ready, 1'b1);
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, r);
        chk("post_rst_lw", r, 32'hAABBCCDD);

        for (int t = 0; t < 200; t++)
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                   $urandom, int'($urandom_range(0, 3)), r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
